// File: rtl/f2h_burst_writer.sv
// Drains a valid/ready word stream into an SDRAM ring as AXI3 INCR bursts, one burst outstanding at a time.
// awvalid rises two cycles after the push that completes a burst; s_ready drops only when the input FIFO is full.
module f2h_burst_writer #(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 32,
  parameter int ID_W       = 8,
  parameter int AXI_ID     = 0,
  parameter int MAX_BURST  = 16,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_enable,
  input  logic [ADDR_W-1:0]   cfg_base,
  input  logic [ADDR_W-1:0]   cfg_size,
  input  logic [DATA_W-1:0]   s_data,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic                s_last,
  output logic [ADDR_W-1:0]   wr_ptr,
  output logic                err_resp,
  output logic                busy,
  output logic [ID_W-1:0]     awid,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [3:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic [1:0]          awlock,
  output logic [3:0]          awcache,
  output logic [2:0]          awprot,
  output logic [4:0]          awuser,
  output logic                awvalid,
  input  logic                awready,
  output logic [ID_W-1:0]     wid,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  input  logic [ID_W-1:0]     bid,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready,
  output logic                arvalid,
  output logic                rready
);
  localparam int BYTES = DATA_W / 8;
  localparam int SZ    = $clog2(BYTES);
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CW    = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_AW, S_W, S_B} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]     wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0]     count_q, count_d;
  logic              full_q, full_d, flush_q, flush_d, en_q, err_q, err_d;
  logic              awvalid_q, awvalid_d, wvalid_q, wvalid_d, wlast_q, wlast_d, bready_q, bready_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d, base_q, base_d, size_q, size_d;
  logic [ADDR_W-1:0] off_q, off_d, wr_ptr_q, wr_ptr_d;
  logic [4:0]        len_q, len_d, beat_q, beat_d, len_new;
  logic              push, pop, rise, issue;
  logic [ADDR_W-1:0] cur_addr, ring_beats, k4_beats, cand, off_nxt;
  logic [12:0]       k4_bytes;
  logic              unused_bid;

  assign unused_bid = ^bid;
  assign s_ready  = ~reset & ~full_q;
  assign wr_ptr   = wr_ptr_q;
  assign err_resp = err_q;
  assign busy     = (state_q != S_IDLE) | (count_q != '0);
  assign awid     = ID_W'(AXI_ID);
  assign wid      = ID_W'(AXI_ID);
  assign awaddr   = awaddr_q;
  assign awlen    = 4'(len_q - 5'd1);
  assign awsize   = 3'(SZ);
  assign awburst  = 2'b01;
  assign awlock   = 2'b00;
  assign awcache  = 4'b0011;
  assign awprot   = 3'b000;
  assign awuser   = 5'b00000;
  assign awvalid  = awvalid_q;
  assign wdata    = mem_q[rp_q];
  assign wstrb    = '1;
  assign wlast    = wlast_q;
  assign wvalid   = wvalid_q;
  assign bready   = bready_q;
  assign arvalid  = 1'b0;
  assign rready   = 1'b0;

  // Burst length is the tightest of: burst cap, FIFO occupancy, ring end, next 4 KB page.
  always_comb begin
    push       = s_valid & s_ready;
    pop        = wvalid_q & wready;
    rise       = cfg_enable & ~en_q;
    cur_addr   = base_q + off_q;
    ring_beats = (size_q - off_q) >> SZ;
    k4_bytes   = 13'h1000 - {1'b0, cur_addr[11:0]};
    k4_beats   = ADDR_W'(k4_bytes >> SZ);
    cand       = ADDR_W'(MAX_BURST);
    if (ADDR_W'(count_q) < cand) cand = ADDR_W'(count_q);
    if (ring_beats < cand) cand = ring_beats;
    if (k4_beats < cand) cand = k4_beats;
    len_new    = cand[4:0];
    issue      = (state_q == S_IDLE) && cfg_enable && en_q &&
                 ((count_q >= CW'(MAX_BURST)) || (flush_q && (count_q != '0)));
    off_nxt    = off_q + (ADDR_W'(len_q) << SZ);
    if (off_nxt == size_q) off_nxt = '0;
  end

  always_comb begin
    wp_d    = push ? wp_q + 1'b1 : wp_q;
    rp_d    = pop ? rp_q + 1'b1 : rp_q;
    count_d = count_q;
    if (push && !pop) count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
    full_d  = (count_d == CW'(FIFO_DEPTH));
    flush_d = flush_q;
    if (issue && (CW'(len_new) == count_q)) flush_d = 1'b0;
    if (push && s_last) flush_d = 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    wlast_d   = wlast_q;
    bready_d  = bready_q;
    awaddr_d  = awaddr_q;
    len_d     = len_q;
    beat_d    = beat_q;
    base_d    = base_q;
    size_d    = size_q;
    off_d     = off_q;
    wr_ptr_d  = wr_ptr_q;
    err_d     = err_q;
    case (state_q)
      S_IDLE: begin
        if (rise) begin
          base_d   = cfg_base;
          size_d   = cfg_size;
          off_d    = '0;
          wr_ptr_d = '0;
          err_d    = 1'b0;
        end
        if (issue) begin
          state_d   = S_AW;
          awvalid_d = 1'b1;
          awaddr_d  = cur_addr;
          len_d     = len_new;
        end
      end
      S_AW: begin
        if (awready) begin
          state_d   = S_W;
          awvalid_d = 1'b0;
          wvalid_d  = 1'b1;
          wlast_d   = (len_q == 5'd1);
          beat_d    = '0;
        end
      end
      S_W: begin
        if (wready) begin
          if (wlast_q) begin
            state_d  = S_B;
            wvalid_d = 1'b0;
            wlast_d  = 1'b0;
            bready_d = 1'b1;
          end else begin
            beat_d  = beat_q + 5'd1;
            wlast_d = (beat_q + 5'd2 == len_q);
          end
        end
      end
      default: begin
        if (bvalid) begin
          state_d  = S_IDLE;
          bready_d = 1'b0;
          off_d    = off_nxt;
          wr_ptr_d = off_nxt;
          if (bresp != 2'b00) err_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= s_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      wp_q      <= '0;
      rp_q      <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      flush_q   <= 1'b0;
      en_q      <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      wlast_q   <= 1'b0;
      bready_q  <= 1'b0;
      awaddr_q  <= '0;
      len_q     <= 5'd1;
      beat_q    <= '0;
      base_q    <= '0;
      size_q    <= '0;
      off_q     <= '0;
      wr_ptr_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wp_q      <= wp_d;
      rp_q      <= rp_d;
      count_q   <= count_d;
      full_q    <= full_d;
      flush_q   <= flush_d;
      en_q      <= cfg_enable;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      wlast_q   <= wlast_d;
      bready_q  <= bready_d;
      awaddr_q  <= awaddr_d;
      len_q     <= len_d;
      beat_q    <= beat_d;
      base_q    <= base_d;
      size_q    <= size_d;
      off_q     <= off_d;
      wr_ptr_q  <= wr_ptr_d;
      err_q     <= err_d;
    end
  end
endmodule

// File: tb/tb_f2h_burst_writer.sv
// Scoreboarded bench for f2h_burst_writer: stream words and expected bursts are queued at stimulus time
// and checked against the AXI write channels by a negedge monitor.
module tb_f2h_burst_writer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_enable = 1'b0;
  logic [31:0] cfg_base = '0, cfg_size = '0;
  logic [63:0] s_data = '0;
  logic        s_valid = 1'b0, s_ready, s_last = 1'b0;
  logic [31:0] wr_ptr;
  logic        err_resp, busy;
  logic [7:0]  awid, wid, bid;
  logic [31:0] awaddr;
  logic [3:0]  awlen, awcache;
  logic [2:0]  awsize, awprot;
  logic [1:0]  awburst, awlock, bresp;
  logic [4:0]  awuser;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready, arvalid, rready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;

  f2h_burst_writer dut (
    .clk(clk), .reset(reset), .cfg_enable(cfg_enable), .cfg_base(cfg_base), .cfg_size(cfg_size),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
    .wr_ptr(wr_ptr), .err_resp(err_resp), .busy(busy),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awlock(awlock),
    .awcache(awcache), .awprot(awprot), .awuser(awuser), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready), .arvalid(arvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  int          vectors = 0, miscompares = 0;
  logic [63:0] exp_data[$];
  logic [35:0] exp_aw[$];
  logic [35:0] e;
  logic [63:0] d;
  bit          stall = 0, exp_err = 0, b_pend = 0;
  bit          aw_hs = 0, w_hs = 0, wlast_hs = 0, b_hs = 0;
  int          err_at = -1, b_count = 0, beat_idx = 0, seq = 0;
  logic [3:0]  cur_len = '0;

  initial begin
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00; bid = 8'h00;
  end

  // Handshake flags sampled here describe the transfer that completes at the next rising edge.
  always @(negedge clk) begin
    aw_hs    = awvalid && awready;
    w_hs     = wvalid && wready;
    wlast_hs = w_hs && wlast;
    b_hs     = bvalid && bready;
    if (!reset) begin
      if (aw_hs) begin
        vectors++;
        if (exp_aw.size() == 0) begin
          miscompares++;
          $display("FAIL aw_unexpected: got awaddr=%h awlen=%0d, required no burst", awaddr, awlen);
        end else begin
          e = exp_aw.pop_front();
          if ({awaddr, awlen} !== e) begin
            miscompares++;
            $display("FAIL aw_burst: got addr=%h len=%0d, required addr=%h len=%0d", awaddr, awlen, e[35:4], e[3:0]);
          end
        end
        cur_len  = awlen;
        beat_idx = 0;
      end
      if (w_hs) begin
        vectors++;
        if (exp_data.size() == 0) begin
          miscompares++;
          $display("FAIL w_unexpected: got wdata=%h, required no beat", wdata);
        end else begin
          d = exp_data.pop_front();
          if (wdata !== d) begin
            miscompares++;
            $display("FAIL wdata: got %h, required %h", wdata, d);
          end
        end
        vectors++;
        if (wlast !== (beat_idx == int'(cur_len))) begin
          miscompares++;
          $display("FAIL wlast: got %b on beat %0d of len %0d", wlast, beat_idx, cur_len + 1);
        end
        beat_idx++;
      end
      if (b_hs) begin
        vectors++;
        if (err_resp !== exp_err) begin
          miscompares++;
          $display("FAIL err_resp_at_b: got %b, required %b", err_resp, exp_err);
        end
        if (bresp != 2'b00) exp_err = 1;
        b_count++;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (reset) begin
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00; b_pend = 0;
    end else begin
      if (b_hs) begin
        bvalid = 1'b0;
        bresp  = 2'b00;
      end
      if (wlast_hs) b_pend = 1;
      if (b_pend && !bvalid && (!stall || $urandom_range(0, 2) == 0)) begin
        bvalid = 1'b1;
        bresp  = (b_count == err_at) ? 2'b10 : 2'b00;
        b_pend = 0;
      end
      awready = !stall || ($urandom_range(0, 1) == 1);
      wready  = !stall || ($urandom_range(0, 1) == 1);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic push_words(input int n, input bit last);
    for (int i = 0; i < n; i++) begin
      int guard = 0;
      s_data  = {seq[31:0] ^ 32'hDEAD_0000, seq[31:0]};
      s_valid = 1'b1;
      s_last  = last && (i == n - 1);
      @(negedge clk);
      while (!s_ready && guard < 2000) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 2000) begin
        vectors++; miscompares++;
        $display("FAIL push_timeout: s_ready stuck 0, required 1");
      end else begin
        exp_data.push_back(s_data);
      end
      seq++;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    @(negedge clk);
    while ((busy || exp_data.size() != 0 || exp_aw.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      vectors++; miscompares++;
      $display("FAIL drain_timeout: busy=%b data_left=%0d bursts_left=%0d, required all 0", busy, exp_data.size(), exp_aw.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic configure(input logic [31:0] base, input logic [31:0] size);
    cfg_enable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cfg_base = base; cfg_size = size; cfg_enable = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    exp_err = 0;
    vectors++;
    if (wr_ptr !== 32'h0) begin miscompares++; $display("FAIL cfg_wr_ptr: got %h, required 0", wr_ptr); end
    vectors++;
    if (err_resp !== 1'b0) begin miscompares++; $display("FAIL cfg_err: got %b, required 0", err_resp); end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    vectors++;
    if ({s_ready, awvalid, wvalid, wlast, bready, err_resp, busy} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got rdy/awv/wv/wl/br/err/busy=%b, required 0000000", {s_ready, awvalid, wvalid, wlast, bready, err_resp, busy});
    end
    vectors++;
    if (wr_ptr !== 32'h0) begin miscompares++; $display("FAIL reset_wr_ptr: got %h, required 0", wr_ptr); end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (s_ready !== 1'b1) begin miscompares++; $display("FAIL post_reset_ready: got %b, required 1", s_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_two_bursts;
    configure(32'h2000_0000, 32'h1000);
    exp_aw.push_back({32'h2000_0000, 4'd15});
    exp_aw.push_back({32'h2000_0080, 4'd15});
    push_words(32, 0);
    wait_idle(500);
    vectors++;
    if (wr_ptr !== 32'h100) begin miscompares++; $display("FAIL two_bursts_wr_ptr: got %h, required 100", wr_ptr); end
  endtask

  task automatic test_flush;
    configure(32'h2000_0000, 32'h1000);
    exp_aw.push_back({32'h2000_0000, 4'd4});
    push_words(5, 1);
    vectors++;
    if (awvalid !== 1'b0) begin miscompares++; $display("FAIL flush_lat1: awvalid got %b, required 0", awvalid); end
    @(posedge clk); #1;
    vectors++;
    if (awvalid !== 1'b1) begin miscompares++; $display("FAIL flush_lat2: awvalid got %b, required 1", awvalid); end
    wait_idle(200);
    vectors++;
    if (wr_ptr !== 32'h28) begin miscompares++; $display("FAIL flush_wr_ptr: got %h, required 28", wr_ptr); end
    // A lone word without s_last must wait: the flush request was consumed by the burst above.
    push_words(1, 0);
    repeat (20) @(posedge clk);
    #1;
    vectors++;
    if ({busy, awvalid} !== 2'b10) begin miscompares++; $display("FAIL flush_cleared: busy/awvalid got %b, required 10", {busy, awvalid}); end
    exp_aw.push_back({32'h2000_0028, 4'd15});
    push_words(15, 0);
    wait_idle(200);
    vectors++;
    if (wr_ptr !== 32'hA8) begin miscompares++; $display("FAIL flush_next_wr_ptr: got %h, required a8", wr_ptr); end
  endtask

  task automatic test_wrap;
    configure(32'h2000_0000, 32'h0C0);
    exp_aw.push_back({32'h2000_0000, 4'd15});
    exp_aw.push_back({32'h2000_0080, 4'd7});
    exp_aw.push_back({32'h2000_0000, 4'd7});
    push_words(32, 1);
    wait_idle(500);
    vectors++;
    if (wr_ptr !== 32'h40) begin miscompares++; $display("FAIL wrap_wr_ptr: got %h, required 40", wr_ptr); end
  endtask

  task automatic test_4k_split;
    configure(32'h2000_0FC0, 32'h1000);
    exp_aw.push_back({32'h2000_0FC0, 4'd7});
    exp_aw.push_back({32'h2000_1000, 4'd7});
    push_words(16, 1);
    wait_idle(300);
    vectors++;
    if (wr_ptr !== 32'h80) begin miscompares++; $display("FAIL k4_wr_ptr: got %h, required 80", wr_ptr); end
  endtask

  task automatic test_full;
    cfg_enable = 1'b0;
    push_words(64, 0);
    @(negedge clk);
    vectors++;
    if (s_ready !== 1'b0) begin miscompares++; $display("FAIL full_ready: got %b, required 0", s_ready); end
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL full_busy: got %b, required 1", busy); end
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) exp_aw.push_back({32'h2000_0000 + 32'(i * 128), 4'd15});
    configure(32'h2000_0000, 32'h1000);
    wait_idle(800);
    vectors++;
    if (wr_ptr !== 32'h200) begin miscompares++; $display("FAIL full_wr_ptr: got %h, required 200", wr_ptr); end
  endtask

  task automatic test_stalls;
    configure(32'h2000_0000, 32'h1000);
    stall   = 1;
    b_count = 0;
    err_at  = 1;
    exp_aw.push_back({32'h2000_0000, 4'd15});
    exp_aw.push_back({32'h2000_0080, 4'd15});
    exp_aw.push_back({32'h2000_0100, 4'd15});
    push_words(48, 1);
    wait_idle(3000);
    stall  = 0;
    err_at = -1;
    vectors++;
    if (wr_ptr !== 32'h180) begin miscompares++; $display("FAIL stall_wr_ptr: got %h, required 180", wr_ptr); end
    vectors++;
    if (err_resp !== 1'b1) begin miscompares++; $display("FAIL stall_err: got %b, required 1", err_resp); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int n = 0;
    configure(32'h2000_0000, 32'h1000);
    exp_aw.push_back({32'h2000_0000, 4'd15});
    exp_aw.push_back({32'h2000_0080, 4'd15});
    push_words(32, 0);
    @(posedge clk); #2;
    while (!(wvalid && beat_idx == 2 && awaddr == 32'h2000_0080) && n < 300) begin
      @(posedge clk); #2;
      n++;
    end
    vectors++;
    if (n >= 300) begin miscompares++; $display("FAIL reset_mid_wait: third beat of second burst never seen"); end
    vectors++;
    if (wr_ptr !== 32'h80) begin miscompares++; $display("FAIL reset_mid_pre_ptr: got %h, required 80", wr_ptr); end
    reset = 1'b1;
    #1;
    vectors++;
    if ({awvalid, wvalid, wlast, bready, s_ready, busy} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_mid_ctrl: awv/wv/wl/br/rdy/busy got %b, required 000000", {awvalid, wvalid, wlast, bready, s_ready, busy});
    end
    vectors++;
    if (wr_ptr !== 32'h0) begin miscompares++; $display("FAIL reset_mid_ptr: got %h, required 0", wr_ptr); end
    exp_data.delete();
    exp_aw.delete();
    exp_err  = 0;
    beat_idx = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    exp_aw.push_back({32'h2000_0000, 4'd15});
    push_words(16, 0);
    wait_idle(300);
    vectors++;
    if (wr_ptr !== 32'h80) begin miscompares++; $display("FAIL reset_mid_restart_ptr: got %h, required 80", wr_ptr); end
  endtask

  initial begin
    test_reset();
    test_two_bursts();
    test_flush();
    test_wrap();
    test_4k_split();
    test_full();
    test_stalls();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
